// File: rtl/merge_n_if.sv
// Handshake bundle for merge_n: N upstream 4-phase channels in, one downstream 4-phase channel out.
interface merge_n_if #(
  parameter int N  = 3,
  parameter int DW = 32
);
  logic [N-1:0]         req_in;
  logic [N-1:0][DW-1:0] din;
  logic [N-1:0]         sel;
  logic [N-1:0]         ack_out;
  logic                 req_out;
  logic [DW-1:0]        dout;
  logic                 ack_in;
  logic                 busy;
  logic                 sel_err;

  modport slave (
    input  req_in, din, sel, ack_in,
    output ack_out, req_out, dout, busy, sel_err
  );

  modport master (
    output req_in, din, sel, ack_in,
    input  ack_out, req_out, dout, busy, sel_err
  );
endinterface

// File: rtl/merge_n.sv
// N-channel 4-phase merge: steered by one-hot sel (MODE=0) or round-robin arbitrated (MODE=1),
// registered handshake FSM IDLE -> FWD -> HOLD -> RTZ with payload capture on grant.
module merge_n #(
  parameter int N    = 3,
  parameter int DW   = 32,
  parameter int MODE = 0
) (
  input logic       clk,
  input logic       rst_n,
  merge_n_if.slave  bus
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, FWD, HOLD, RTZ} state_t;

  state_t        state, state_d;
  logic [IW-1:0] gnt, gnt_d, rr, rr_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          req_q, req_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          sel_one, sel_hit, err_cond, cand_vld, rr_vld;
  logic [IW-1:0] sel_idx, rr_idx, cand, rr_next;
  logic [IW:0]   scan, rr_inc;

  assign sel_one  = (bus.sel != '0) && ((bus.sel & (bus.sel - N'(1))) == '0);
  assign sel_hit  = |(bus.sel & bus.req_in);
  assign err_cond = (MODE == 0) && !sel_one && (bus.req_in != '0);

  always_comb begin : sel_enc
    sel_idx = '0;
    for (int k = 0; k < N; k++)
      if (bus.sel[k]) sel_idx = IW'(k);
  end

  // Scan from the farthest slot back toward rr so the last hit is the first in rr order.
  always_comb begin : rr_scan
    rr_vld = 1'b0;
    rr_idx = '0;
    scan   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      scan = {1'b0, rr} + (IW+1)'(i);
      if (scan >= (IW+1)'(N)) scan = scan - (IW+1)'(N);
      if (bus.req_in[scan[IW-1:0]]) begin
        rr_vld = 1'b1;
        rr_idx = scan[IW-1:0];
      end
    end
  end

  always_comb begin : cand_sel
    if (MODE == 0) begin
      cand_vld = sel_one && sel_hit;
      cand     = sel_idx;
    end else begin
      cand_vld = rr_vld;
      cand     = rr_idx;
    end
    rr_inc  = {1'b0, gnt} + (IW+1)'(1);
    rr_next = (rr_inc == (IW+1)'(N)) ? '0 : rr_inc[IW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      rr     <= '0;
      ack_q  <= '0;
      req_q  <= 1'b0;
      dout_q <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      gnt    <= gnt_d;
      rr     <= rr_d;
      ack_q  <= ack_d;
      req_q  <= req_d;
      dout_q <= dout_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Protocol violations (ack_in dropping in FWD, early req drop) just leave the FSM waiting.
  always_comb begin : next_state
    state_d = state;
    case (state)
      IDLE:    if (cand_vld)          state_d = FWD;
      FWD:     if (bus.ack_in)        state_d = HOLD;
      HOLD:    if (!bus.req_in[gnt])  state_d = RTZ;
      RTZ:     if (!bus.ack_in)       state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin : out_next
    gnt_d  = gnt;
    rr_d   = rr;
    ack_d  = ack_q;
    req_d  = req_q;
    dout_d = dout_q;
    err_d  = 1'b0;
    busy_d = (state_d != IDLE);
    case (state)
      IDLE: begin
        err_d = err_cond;
        if (cand_vld) begin
          gnt_d  = cand;
          dout_d = bus.din[cand];
          req_d  = 1'b1;
        end
      end
      FWD:  if (bus.ack_in)       ack_d = N'(1) << gnt;
      HOLD: if (!bus.req_in[gnt]) req_d = 1'b0;
      RTZ: begin
        if (!bus.ack_in) begin
          ack_d = '0;
          if (MODE == 1) rr_d = rr_next;
        end
      end
      default: ;
    endcase
  end

  assign bus.ack_out = ack_q;
  assign bus.req_out = req_q;
  assign bus.dout    = dout_q;
  assign bus.busy    = busy_q;
  assign bus.sel_err = err_q;
endmodule

// File: tb/tb_merge_n.sv
// Bench for merge_n: steered N=3 (u0), round-robin N=4 (u1), round-robin N=3 (u2), scoreboarded grants.
module tb_merge_n;
  logic clk, rst_n;

  typedef struct {
    int          d;
    int          ch;
    logic [31:0] data;
  } exp_t;

  // Per-DUT views widened to 4 channels so tasks can index by DUT number.
  logic [3:0]       req_in_t [3];
  logic [3:0][31:0] din_t    [3];
  logic [3:0]       sel_t    [3];
  logic             ack_in_t [3];
  logic [3:0]       ack_out_t[3];
  logic             req_out_t[3];
  logic [31:0]      dout_t   [3];
  logic             busy_t   [3];
  logic             err_t    [3];
  int               dly_t    [3];

  merge_n_if #(.N(3), .DW(32)) s0 ();
  merge_n_if #(.N(4), .DW(32)) s1 ();
  merge_n_if #(.N(3), .DW(32)) s2 ();

  merge_n #(.N(3), .DW(32), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(s0.slave));
  merge_n #(.N(4), .DW(32), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(s1.slave));
  merge_n #(.N(3), .DW(32), .MODE(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(s2.slave));

  assign s0.req_in = req_in_t[0][2:0];
  assign s0.din    = din_t[0][2:0];
  assign s0.sel    = sel_t[0][2:0];
  assign s0.ack_in = ack_in_t[0];
  assign s1.req_in = req_in_t[1];
  assign s1.din    = din_t[1];
  assign s1.sel    = sel_t[1];
  assign s1.ack_in = ack_in_t[1];
  assign s2.req_in = req_in_t[2][2:0];
  assign s2.din    = din_t[2][2:0];
  assign s2.sel    = sel_t[2][2:0];
  assign s2.ack_in = ack_in_t[2];

  assign ack_out_t[0] = {1'b0, s0.ack_out};
  assign ack_out_t[1] = s1.ack_out;
  assign ack_out_t[2] = {1'b0, s2.ack_out};
  assign req_out_t[0] = s0.req_out;
  assign req_out_t[1] = s1.req_out;
  assign req_out_t[2] = s2.req_out;
  assign dout_t[0]    = s0.dout;
  assign dout_t[1]    = s1.dout;
  assign dout_t[2]    = s2.dout;
  assign busy_t[0]    = s0.busy;
  assign busy_t[1]    = s1.busy;
  assign busy_t[2]    = s2.busy;
  assign err_t[0]     = s0.sel_err;
  assign err_t[1]     = s1.sel_err;
  assign err_t[2]     = s2.sel_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream responder: raise ack_in dly_t cycles after req_out, drop it once req_out drops.
  int ds_cnt[3] = '{0, 0, 0};
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        ack_in_t[d] <= 1'b0;
        ds_cnt[d]   <= 0;
      end else if (req_out_t[d] && !ack_in_t[d]) begin
        if (ds_cnt[d] >= dly_t[d]) begin
          ack_in_t[d] <= 1'b1;
          ds_cnt[d]   <= 0;
        end else ds_cnt[d] <= ds_cnt[d] + 1;
      end else if (!req_out_t[d] && ack_in_t[d]) ack_in_t[d] <= 1'b0;
    end
  end

  // Monitor: record dout at each req_out rise, the ack_out vector at each ack rise, and overlaps.
  logic [31:0] obs_dout[3][16];
  logic [3:0]  obs_ack [3][16];
  int          obs_n[3] = '{0, 0, 0};
  int          ack_n[3] = '{0, 0, 0};
  int          ovl[3]   = '{0, 0, 0};
  logic        pr_req[3] = '{1'b0, 1'b0, 1'b0};
  logic [3:0]  pr_ack[3] = '{4'h0, 4'h0, 4'h0};
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (req_out_t[d] && !pr_req[d]) begin
        obs_dout[d][obs_n[d] % 16] <= dout_t[d];
        obs_n[d] <= obs_n[d] + 1;
      end
      if (ack_out_t[d] != 4'h0 && pr_ack[d] == 4'h0) begin
        obs_ack[d][ack_n[d] % 16] <= ack_out_t[d];
        ack_n[d] <= ack_n[d] + 1;
      end
      if ($countones(ack_out_t[d]) > 1) ovl[d] <= ovl[d] + 1;
      pr_req[d] <= req_out_t[d];
      pr_ack[d] <= ack_out_t[d];
    end
  end

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  exp_t e;
  int   rd_n[3] = '{0, 0, 0};

  // Upstream 4-phase agent: each channel in mask completes rep transactions, re-requesting after ack falls.
  task automatic serve(input int d, input logic [3:0] mask, input int rep, input int budget,
                       output logic ok);
    int cnt[4];
    logic [3:0] inack;
    bit done;
    for (int k = 0; k < 4; k++) cnt[k] = mask[k] ? rep : 0;
    inack = 4'h0;
    ok = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (ack_out_t[d][k]) begin
          req_in_t[d][k] = 1'b0;
          inack[k] = 1'b1;
        end else begin
          if (inack[k]) begin
            inack[k] = 1'b0;
            if (cnt[k] > 0) cnt[k]--;
          end
          req_in_t[d][k] = (cnt[k] > 0);
        end
      end
      done = 1'b1;
      for (int k = 0; k < 4; k++) if (cnt[k] > 0) done = 1'b0;
      if (done && !busy_t[d] && ack_out_t[d] == 4'h0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic ok;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_in_t[d] = 4'h0;
      sel_t[d]    = 4'h0;
    end
    dly_t = '{2, 0, 0};
    din_t[0] = {32'h0, 32'h0C0C_0002, 32'hA5A5_0001, 32'h0A0A_0000};
    din_t[1] = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
    din_t[2] = {32'h0, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000};
    req_in_t[2] = 4'b0111;
    req_in_t[0] = 4'b0111;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if ({req_out_t[d], ack_out_t[d], busy_t[d], err_t[d], dout_t[d]} !== 39'h0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: req_out=%b ack_out=%b busy=%b sel_err=%b dout=%h, expected all 0",
                 d, req_out_t[d], ack_out_t[d], busy_t[d], err_t[d], dout_t[d]);
      end
    end
    req_in_t[0] = 4'h0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) sbq.push_back('{2, k, din_t[2][k]});
    @(negedge clk);
    n_chk++;
    if (req_out_t[2] !== 1'b1 || dout_t[2] !== din_t[2][0]) begin
      n_fail++;
      $display("FAIL reset_first_grant: req_out=%b dout=%h, expected 1 %h", req_out_t[2], dout_t[2], din_t[2][0]);
    end
    serve(2, 4'b0111, 1, 80, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL reset_serve_timeout: done=0, expected 1"); end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_chk++;
      if (obs_dout[e.d][rd_n[e.d] % 16] !== e.data || obs_ack[e.d][rd_n[e.d] % 16] !== (4'b0001 << e.ch)) begin
        n_fail++;
        $display("FAIL reset_sb dut%0d: dout=%h ack=%b, expected dout=%h ack=%b", e.d,
                 obs_dout[e.d][rd_n[e.d] % 16], obs_ack[e.d][rd_n[e.d] % 16], e.data, 4'b0001 << e.ch);
      end
      rd_n[e.d]++;
    end
  endtask

  task automatic test_steered();
    logic ok;
    sel_t[0] = 4'b0010;
    @(negedge clk);
    n_chk++;
    if (req_out_t[0] !== 1'b0) begin n_fail++; $display("FAIL steer_idle: req_out=%b, expected 0", req_out_t[0]); end
    req_in_t[0] = 4'b0010;
    sbq.push_back('{0, 1, din_t[0][1]});
    @(negedge clk);
    n_chk++;
    if (req_out_t[0] !== 1'b1 || dout_t[0] !== 32'hA5A5_0001 || busy_t[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL steer_grant: req_out=%b dout=%h busy=%b, expected 1 a5a50001 1", req_out_t[0], dout_t[0], busy_t[0]);
    end
    serve(0, 4'b0010, 1, 40, ok);
    n_chk++;
    if (!ok || busy_t[0] !== 1'b0 || req_out_t[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL steer_complete: done=%b busy=%b req_out=%b, expected 1 0 0", ok, busy_t[0], req_out_t[0]);
    end
    n_chk++;
    if (ovl[0] !== 0) begin n_fail++; $display("FAIL steer_overlap: %0d cycles, expected 0", ovl[0]); end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_chk++;
      if (obs_dout[e.d][rd_n[e.d] % 16] !== e.data || obs_ack[e.d][rd_n[e.d] % 16] !== (4'b0001 << e.ch)) begin
        n_fail++;
        $display("FAIL steer_sb dut%0d: dout=%h ack=%b, expected dout=%h ack=%b", e.d,
                 obs_dout[e.d][rd_n[e.d] % 16], obs_ack[e.d][rd_n[e.d] % 16], e.data, 4'b0001 << e.ch);
      end
      rd_n[e.d]++;
    end
  endtask

  task automatic test_invalid_sel();
    logic ok;
    @(negedge clk);
    sel_t[0]    = 4'b0011;
    req_in_t[0] = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (err_t[0] !== 1'b1 || req_out_t[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL sel_err_cycle%0d: sel_err=%b req_out=%b, expected 1 0", i, err_t[0], req_out_t[0]);
      end
    end
    sel_t[0] = 4'b0001;
    sbq.push_back('{0, 0, din_t[0][0]});
    @(negedge clk);
    n_chk++;
    if (err_t[0] !== 1'b0 || req_out_t[0] !== 1'b1 || dout_t[0] !== din_t[0][0]) begin
      n_fail++;
      $display("FAIL sel_recover: sel_err=%b req_out=%b dout=%h, expected 0 1 %h", err_t[0], req_out_t[0], dout_t[0], din_t[0][0]);
    end
    serve(0, 4'b0001, 1, 40, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL sel_serve_timeout: done=0, expected 1"); end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_chk++;
      if (obs_dout[e.d][rd_n[e.d] % 16] !== e.data || obs_ack[e.d][rd_n[e.d] % 16] !== (4'b0001 << e.ch)) begin
        n_fail++;
        $display("FAIL sel_sb dut%0d: dout=%h ack=%b, expected dout=%h ack=%b", e.d,
                 obs_dout[e.d][rd_n[e.d] % 16], obs_ack[e.d][rd_n[e.d] % 16], e.data, 4'b0001 << e.ch);
      end
      rd_n[e.d]++;
    end
    n_chk++;
    if (obs_n[0] != rd_n[0]) begin n_fail++; $display("FAIL dut0_grant_count: %0d, expected %0d", obs_n[0], rd_n[0]); end
  endtask

  task automatic test_round_robin();
    logic ok;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) sbq.push_back('{1, k, din_t[1][k]});
    serve(1, 4'b1111, 2, 300, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL rr_serve_timeout: done=0, expected 1"); end
    n_chk++;
    if (ovl[1] !== 0) begin n_fail++; $display("FAIL rr_overlap: %0d cycles, expected 0", ovl[1]); end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_chk++;
      if (obs_dout[e.d][rd_n[e.d] % 16] !== e.data || obs_ack[e.d][rd_n[e.d] % 16] !== (4'b0001 << e.ch)) begin
        n_fail++;
        $display("FAIL rr_order dut%0d: dout=%h ack=%b, expected dout=%h ack=%b", e.d,
                 obs_dout[e.d][rd_n[e.d] % 16], obs_ack[e.d][rd_n[e.d] % 16], e.data, 4'b0001 << e.ch);
      end
      rd_n[e.d]++;
    end
    n_chk++;
    if (obs_n[1] != rd_n[1]) begin n_fail++; $display("FAIL dut1_grant_count: %0d, expected %0d", obs_n[1], rd_n[1]); end
  endtask

  task automatic test_hold_off();
    logic ok, leak;
    int cyc;
    leak = 1'b0;
    @(negedge clk);
    sbq.push_back('{2, 0, din_t[2][0]});
    sbq.push_back('{2, 2, din_t[2][2]});
    req_in_t[2] = 4'b0001;
    cyc = 0;
    while (!ack_out_t[2][0] && cyc < 20) begin @(negedge clk); cyc++; end
    n_chk++;
    if (ack_out_t[2][0] !== 1'b1) begin n_fail++; $display("FAIL hold_reach: ack_out=%b, expected 0001", ack_out_t[2]); end
    req_in_t[2][2] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ack_out_t[2] !== 4'b0001) leak = 1'b1;
    end
    req_in_t[2][0] = 1'b0;
    cyc = 0;
    while (ack_out_t[2][0] && cyc < 20) begin
      @(negedge clk);
      if (ack_out_t[2][2]) leak = 1'b1;
      cyc++;
    end
    n_chk++;
    if (leak) begin n_fail++; $display("FAIL hold_off_ack2: ack_out[2]=1 while ch0 active, expected 0"); end
    @(negedge clk);
    n_chk++;
    if (req_out_t[2] !== 1'b1 || dout_t[2] !== din_t[2][2]) begin
      n_fail++;
      $display("FAIL hold_off_next_grant: req_out=%b dout=%h, expected 1 %h", req_out_t[2], dout_t[2], din_t[2][2]);
    end
    serve(2, 4'b0100, 1, 40, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL hold_serve_timeout: done=0, expected 1"); end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_chk++;
      if (obs_dout[e.d][rd_n[e.d] % 16] !== e.data || obs_ack[e.d][rd_n[e.d] % 16] !== (4'b0001 << e.ch)) begin
        n_fail++;
        $display("FAIL hold_sb dut%0d: dout=%h ack=%b, expected dout=%h ack=%b", e.d,
                 obs_dout[e.d][rd_n[e.d] % 16], obs_ack[e.d][rd_n[e.d] % 16], e.data, 4'b0001 << e.ch);
      end
      rd_n[e.d]++;
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    sbq.push_back('{2, 1, din_t[2][1]});
    req_in_t[2] = 4'b0010;
    cyc = 0;
    while (!ack_out_t[2][1] && cyc < 20) begin @(negedge clk); cyc++; end
    n_chk++;
    if (ack_out_t[2] !== 4'b0010) begin n_fail++; $display("FAIL midrst_hold: ack_out=%b, expected 0010", ack_out_t[2]); end
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if (req_out_t[2] !== 1'b0 || ack_out_t[2] !== 4'h0 || busy_t[2] !== 1'b0 || dout_t[2] !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_async: req_out=%b ack_out=%b busy=%b dout=%h, expected 0 0000 0 0",
               req_out_t[2], ack_out_t[2], busy_t[2], dout_t[2]);
    end
    req_in_t[2] = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy_t[2] !== 1'b0 || req_out_t[2] !== 1'b0 || ack_out_t[2] !== 4'h0) begin
      n_fail++;
      $display("FAIL midrst_idle: busy=%b req_out=%b ack_out=%b, expected 0 0 0000", busy_t[2], req_out_t[2], ack_out_t[2]);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_chk++;
      if (obs_dout[e.d][rd_n[e.d] % 16] !== e.data || obs_ack[e.d][rd_n[e.d] % 16] !== (4'b0001 << e.ch)) begin
        n_fail++;
        $display("FAIL midrst_sb dut%0d: dout=%h ack=%b, expected dout=%h ack=%b", e.d,
                 obs_dout[e.d][rd_n[e.d] % 16], obs_ack[e.d][rd_n[e.d] % 16], e.data, 4'b0001 << e.ch);
      end
      rd_n[e.d]++;
    end
    n_chk++;
    if (obs_n[2] != rd_n[2]) begin n_fail++; $display("FAIL dut2_grant_count: %0d, expected %0d", obs_n[2], rd_n[2]); end
  endtask

  initial begin
    test_reset();
    test_steered();
    test_invalid_sel();
    test_round_robin();
    test_hold_off();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
